// File: rtl/cia_serial_port.sv
// CIA serial data port (SDR). Output mode shifts sdr out MSB-first on SP,
// clocked by Timer A underflows, and drives CNT; input mode shifts SP in on
// rising CNT edges. Produces the one-phi2-period SP interrupt source.
//
// state | meaning
// IDLE  | no byte in flight (output mode waits for a full buffer, input mode lives here)
// SHIFT | output byte in progress; CNT toggles on every Timer A underflow
module cia_serial_port #(
  parameter int NBITS = 8
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       phi2_dn,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] data,
  input  logic       sp_mode,
  input  logic       ta_underflow,
  input  logic       cnt_in,
  input  logic       sp_in,
  output logic       cnt_out,
  output logic       sp_out,
  output logic [7:0] sdr,
  output logic       irq_sp
);

  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, nxt_state;
  logic [NBITS-1:0] shifter, nxt_shifter;
  logic [7:0]       nxt_sdr;
  logic [CW-1:0]    bitcnt, nxt_bitcnt;
  logic             buf_full, nxt_buf_full;
  logic             nxt_cnt_out, nxt_sp_out, nxt_irq;
  logic             cnt_prev, mode_prev;

  logic             wr_sdr, mode_chg, cnt_rise, load, rx_done;
  logic [NBITS-1:0] rx_shift;

  assign wr_sdr   = we && (addr == 4'hC) && phi2_dn;
  assign mode_chg = (sp_mode != mode_prev);
  assign cnt_rise = !cnt_prev && cnt_in;
  // A new byte starts from IDLE or right after the last bit's rising toggle,
  // never on the same underflow that finishes the previous byte.
  assign load     = sp_mode && ta_underflow && buf_full &&
                    ((state == IDLE) || (bitcnt == '0));
  assign rx_shift = {shifter[NBITS-2:0], sp_in};
  assign rx_done  = cnt_rise && (bitcnt == CW'(NBITS - 1));

  // State and datapath registers; everything advances only on phi2_dn.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state     <= IDLE;
      sdr       <= '0;
      shifter   <= '0;
      bitcnt    <= '0;
      buf_full  <= 1'b0;
      cnt_out   <= 1'b1;
      sp_out    <= 1'b1;
      irq_sp    <= 1'b0;
      cnt_prev  <= 1'b1;
      mode_prev <= 1'b0;
    end else if (phi2_dn) begin
      state     <= nxt_state;
      sdr       <= nxt_sdr;
      shifter   <= nxt_shifter;
      bitcnt    <= nxt_bitcnt;
      buf_full  <= nxt_buf_full;
      cnt_out   <= nxt_cnt_out;
      sp_out    <= nxt_sp_out;
      irq_sp    <= nxt_irq;
      cnt_prev  <= cnt_in;
      mode_prev <= sp_mode;
    end
  end

  // Next-state: start on load, fall back to IDLE once the last bit is out.
  always_comb begin
    nxt_state = state;
    if (mode_chg || !sp_mode) begin
      nxt_state = IDLE;
    end else if (ta_underflow) begin
      if (load) begin
        nxt_state = SHIFT;
      end else if ((state == SHIFT) && (bitcnt == '0)) begin
        nxt_state = IDLE;
      end
    end
  end

  // Datapath and pin levels for the coming phi2_dn.
  always_comb begin
    nxt_sdr      = sdr;
    nxt_shifter  = shifter;
    nxt_bitcnt   = bitcnt;
    nxt_buf_full = buf_full;
    nxt_cnt_out  = cnt_out;
    nxt_sp_out   = sp_out;
    nxt_irq      = 1'b0;
    if (mode_chg) begin
      nxt_bitcnt   = '0;
      nxt_cnt_out  = 1'b1;
      nxt_sp_out   = 1'b1;
      nxt_buf_full = 1'b0;
      if (wr_sdr) nxt_sdr = data;
    end else if (sp_mode) begin
      if (ta_underflow) begin
        if (load) begin
          nxt_shifter  = sdr;
          nxt_buf_full = 1'b0;
          nxt_sp_out   = sdr[NBITS-1];
          nxt_cnt_out  = 1'b0;
          nxt_bitcnt   = CW'(NBITS);
        end else if ((state == SHIFT) && (bitcnt != '0)) begin
          if (!cnt_out) begin
            nxt_cnt_out = 1'b1;
            nxt_bitcnt  = bitcnt - CW'(1);
            nxt_irq     = (bitcnt == CW'(1));
          end else begin
            nxt_cnt_out = 1'b0;
            nxt_shifter = shifter << 1;
            nxt_sp_out  = shifter[NBITS-2];
          end
        end
      end
      // A write that coincides with a reload keeps the new byte pending.
      if (wr_sdr) begin
        nxt_sdr      = data;
        nxt_buf_full = 1'b1;
      end
    end else begin
      nxt_cnt_out  = 1'b1;
      nxt_sp_out   = 1'b1;
      nxt_buf_full = 1'b0;
      if (wr_sdr) nxt_sdr = data;
      if (cnt_rise) begin
        nxt_shifter = rx_shift;
        if (rx_done) begin
          // The received byte wins over a simultaneous CPU write.
          nxt_sdr    = rx_shift;
          nxt_bitcnt = '0;
          nxt_irq    = 1'b1;
        end else begin
          nxt_bitcnt = bitcnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cia_serial_port.sv
// Bench for cia_serial_port: stimulus pushes expected serial bits and
// expected interrupt payloads into queues; a monitor pops them on CNT rising
// edges and irq_sp pulses.
module tb_cia_serial_port;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       phi2_dn = 1'b0;
  logic       we = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] data = 8'h00;
  logic       sp_mode = 1'b1;
  logic       ta_underflow = 1'b0;
  logic       cnt_in = 1'b1;
  logic       sp_in = 1'b1;
  logic       cnt_out, sp_out, irq_sp;
  logic [7:0] sdr;

  cia_serial_port #(.NBITS(8)) dut (
    .clk(clk), .res_n(res_n), .phi2_dn(phi2_dn), .we(we), .addr(addr),
    .data(data), .sp_mode(sp_mode), .ta_underflow(ta_underflow),
    .cnt_in(cnt_in), .sp_in(sp_in), .cnt_out(cnt_out), .sp_out(sp_out),
    .sdr(sdr), .irq_sp(irq_sp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int toggles = 0;
  bit exp_bits[$];
  int exp_irq[$];
  logic [3:0] wa = 4'hC;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // One phi2 period = two clks; the posedge with phi2_dn=1 is the event.
  task automatic tick(input bit uf, input bit wr, input logic [7:0] d);
    @(negedge clk);
    phi2_dn = 1'b1; ta_underflow = uf; we = wr; data = d; addr = wr ? wa : 4'h0;
    @(negedge clk);
    phi2_dn = 1'b0; ta_underflow = 1'b0; we = 1'b0;
  endtask

  task automatic push_byte_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  // Idle phi2 periods between underflows: fixed 1 when gap_max==0.
  task automatic uf_tick(input int gap_max);
    int g;
    g = (gap_max == 0) ? 1 : int'($urandom_range(gap_max, 1));
    for (int i = 0; i < g; i++) tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
  endtask

  task automatic tx_byte(input logic [7:0] b, input int gap_max);
    tick(1'b0, 1'b1, b);
    push_byte_bits(b);
    exp_irq.push_back(int'(b));
    toggles = 0;
    for (int k = 1; k <= 17; k++) uf_tick(gap_max);
    chk("tx_toggles", toggles, 16);
    chk("tx_idle_cnt", int'(cnt_out), 1);
    chk("tx_bits_left", exp_bits.size(), 0);
  endtask

  task automatic rx_byte(input logic [7:0] b, input bit collide);
    exp_irq.push_back(int'(b));
    for (int i = 7; i >= 0; i--) begin
      cnt_in = 1'b0; sp_in = b[i];
      tick(1'b0, 1'b0, 8'h00);
      cnt_in = 1'b1;
      tick(1'b0, collide && (i == 0), 8'h55);
    end
    chk("rx_sdr", int'(sdr), int'(b));
    chk("rx_irq_left", exp_irq.size(), 0);
  endtask

  // Monitor: sample #1 after each event edge and consume expectations.
  bit ev, rs, prev_cnt = 1'b1, prev_irq = 1'b0;
  always begin
    @(posedge clk);
    ev = phi2_dn;
    rs = res_n;
    #1;
    if (!rs) begin
      prev_cnt = cnt_out;
      prev_irq = irq_sp;
    end else if (ev) begin
      if (cnt_out != prev_cnt) toggles++;
      if (!prev_cnt && cnt_out) begin
        if (exp_bits.size() == 0) report_fail("cnt_rise_unexpected");
        else chk("sp_bit", int'(sp_out), int'(exp_bits.pop_front()));
      end
      if (prev_irq) chk("irq_width", int'(irq_sp), 0);
      else if (irq_sp) begin
        if (exp_irq.size() == 0) report_fail("irq_unexpected");
        else chk("irq_sdr", int'(sdr), exp_irq.pop_front());
      end
      prev_cnt = cnt_out;
      prev_irq = irq_sp;
    end
  end

  initial begin
    logic [7:0] rb;
    repeat (3) @(negedge clk);
    res_n = 1'b1;
    chk("rst_cnt_out", int'(cnt_out), 1);
    chk("rst_sp_out", int'(sp_out), 1);
    chk("rst_sdr", int'(sdr), 0);
    chk("rst_irq", int'(irq_sp), 0);
    tick(1'b0, 1'b0, 8'h00);

    // Output mode, underflow every second phi2.
    tx_byte(8'hA5, 0);

    // Back-to-back: second byte queued mid-transfer.
    tick(1'b0, 1'b1, 8'h0F);
    push_byte_bits(8'h0F);
    toggles = 0;
    for (int k = 1; k <= 6; k++) uf_tick(0);
    tick(1'b0, 1'b1, 8'hF0);
    push_byte_bits(8'hF0);
    exp_irq.push_back(8'hF0);
    exp_irq.push_back(8'hF0);
    for (int k = 7; k <= 33; k++) begin
      uf_tick(0);
      if (k == 17) chk("b2b_no_gap", int'(cnt_out), 0);
    end
    chk("b2b_toggles", toggles, 32);
    chk("b2b_idle_cnt", int'(cnt_out), 1);
    chk("b2b_irq_left", exp_irq.size(), 0);

    // Random bytes with random underflow spacing.
    for (int n = 0; n < 3; n++) begin
      rb = 8'($urandom);
      tx_byte(rb, 3);
    end

    // Abort after three bits, then receive.
    tick(1'b0, 1'b1, 8'hFF);
    exp_bits.push_back(1'b1); exp_bits.push_back(1'b1); exp_bits.push_back(1'b1);
    toggles = 0;
    for (int k = 1; k <= 6; k++) uf_tick(0);
    chk("abort_pre_toggles", toggles, 6);
    sp_mode = 1'b0;
    tick(1'b0, 1'b0, 8'h00);
    chk("abort_cnt_out", int'(cnt_out), 1);
    chk("abort_sp_out", int'(sp_out), 1);
    chk("abort_irq", int'(irq_sp), 0);
    chk("abort_sdr_kept", int'(sdr), 8'hFF);
    rx_byte(8'h3C, 1'b0);
    chk("rx_sp_out_high", int'(sp_out), 1);

    // Collision: received byte wins over write.
    rx_byte(8'h81, 1'b0 | 1'b1);
    // Plain write in input mode, and a write to another register.
    tick(1'b0, 1'b1, 8'h55);
    chk("in_write", int'(sdr), 8'h55);
    wa = 4'h3;
    tick(1'b0, 1'b1, 8'hAA);
    wa = 4'hC;
    chk("other_addr", int'(sdr), 8'h55);
    for (int n = 0; n < 3; n++) begin
      rb = 8'($urandom);
      rx_byte(rb, n[0]);
    end

    // Reset in the middle of an output transfer.
    sp_mode = 1'b1;
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'hC3);
    exp_bits.push_back(1'b1); exp_bits.push_back(1'b1);
    for (int k = 1; k <= 5; k++) uf_tick(0);
    chk("mid_cnt_low", int'(cnt_out), 0);
    @(negedge clk); res_n = 1'b0;
    @(negedge clk); res_n = 1'b1;
    chk("mid_rst_cnt", int'(cnt_out), 1);
    chk("mid_rst_sp", int'(sp_out), 1);
    chk("mid_rst_sdr", int'(sdr), 0);
    chk("mid_rst_irq", int'(irq_sp), 0);
    toggles = 0;
    for (int k = 1; k <= 6; k++) uf_tick(0);
    chk("post_rst_toggles", toggles, 0);
    chk("bits_left", exp_bits.size(), 0);
    chk("irq_left", exp_irq.size(), 0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cia_serial_port.md
Name: cia_serial_port

Overview:
- Serial data port (SDR, register $C) of the CIA.
- Output mode: shifts a byte out on SP, clocked by Timer A underflows, and drives CNT.
- Input mode: shifts a byte in from SP on rising CNT edges.
- Generates the SP interrupt source (sources[3]) consumed by the interrupt controller; it is the producing end of that source line.

Parameters:
- NBITS, 8, bits per serial transfer (fixed at 8 for 6526 compatibility; counter width is derived from it).

Ports:
- clk  in  1  system clock
- res_n  in  1  synchronous reset, active low
- phi2_dn  in  1  one-clk strobe marking the end of each phi2 cycle; all register and serial events occur on it
- we  in  1  bus write
- addr  in  4  register address
- data  in  8  write data
- sp_mode  in  1  CRA bit 6: 0 = input, 1 = output
- ta_underflow  in  1  Timer A underflow, valid when phi2_dn is high
- cnt_in  in  1  CNT pin, synchronized
- sp_in  in  1  SP pin, synchronized
- cnt_out  out  1  CNT drive level (1 = released/high)
- sp_out  out  1  SP drive level
- sdr  out  8  SDR read value
- irq_sp  out  1  SP interrupt source

Behaviour:
- Event timing: all state updates occur only on clk edges with phi2_dn=1. wr_sdr = we && addr=='hC && phi2_dn.
- Reset (res_n=0 at clk edge), all state cleared regardless of phi2_dn:
  - sdr=0, shifter=0, bitcnt=0, buf_full=0, state=IDLE
  - cnt_out=1, sp_out=1, irq_sp=0, cnt_prev=1
- irq_sp:
  - Set at the phi2_dn that completes a byte; cleared at the next phi2_dn.
  - Held for exactly one phi2 period, so the interrupt controller samples it at phi1.
- Register write: wr_sdr always loads sdr<=data. In output mode it also sets buf_full=1.
- Output mode state machine (sp_mode=1):
  - IDLE, on ta_underflow with buf_full=1: shifter<=sdr, buf_full<=0, sp_out<=sdr[7], cnt_out<=0, bitcnt<=NBITS, go SHIFT.
  - SHIFT, each ta_underflow toggles cnt_out.
  - Rising toggle (0->1): bitcnt<=bitcnt-1. If this produces 0, set irq_sp.
  - Falling toggle (1->0) with bitcnt>0: shifter<=shifter<<1, sp_out<=shifter[6].
  - SHIFT with bitcnt==0, on next ta_underflow:
    - If buf_full: reload exactly as from IDLE (continuous transmission, cnt_out goes 0).
    - Else: go IDLE, cnt_out stays 1.
  - sp_out holds its last bit in IDLE.
  - 8 bits take 16 underflows. Byte boundary: the irq for byte n and the reload of byte n+1 never occur on the same underflow.
- Input mode (sp_mode=0):
  - cnt_out=1, sp_out=1 constantly; buf_full forced 0.
  - Each phi2_dn: cnt_prev<=cnt_in. Rising edge = !cnt_prev && cnt_in.
  - On rising edge: shifter<={shifter[6:0],sp_in}, bitcnt<=bitcnt+1.
  - When bitcnt reaches NBITS: sdr<=shifted value, bitcnt<=0, irq_sp set.
  - A CPU write to sdr on the same phi2_dn as byte completion loses to the received byte.
- Mode change (sp_mode differs from its value at the previous phi2_dn):
  - Abort any transfer: bitcnt<=0, state=IDLE, cnt_out<=1, sp_out<=1, buf_full<=0.
  - No irq. sdr is preserved.
- Simultaneous events:
  - wr_sdr on the underflow that completes the 8th bit: buf_full is seen set, so transmission continues seamlessly.
  - wr_sdr during SHIFT: only updates sdr/buf_full; the shifter is unaffected.
- Reset mid-transfer: immediate return to reset values; no irq is generated.

Test Plan:
- Reset: drive res_n=0 mid-output-transfer -> next cycle cnt_out=1, sp_out=1, sdr=0, irq_sp=0; no further CNT toggles on underflows.
- Transmit 0xA5 in output mode, ta_underflow every 2nd phi2:
  - sp_out sequence at CNT rising edges is 1,0,1,0,0,1,0,1.
  - Exactly 16 CNT toggles.
  - irq_sp high for one phi2 period at the 16th underflow.
  - Then IDLE with cnt_out=1.
- Back-to-back: write 0x0F, then write 0xF0 before the 8th rising edge -> 16 uninterrupted bits 00001111 11110000, two irq pulses, no idle gap.
- Receive in input mode: toggle cnt_in with sp_in bits 0,0,1,1,1,1,0,0 -> sdr=0x3C and one irq_sp pulse after the 8th rising edge, not before.
- Abort: switch sp_mode 1->0 after 3 bits of 0xFF -> cnt_out=1, sp_out=1, no irq; then receiving 8 bits yields a correct byte (bitcnt restarted).
- Write collision: in input mode, wr_sdr=0x55 on the same phi2_dn as the 8th rising edge of 0x81 -> sdr=0x81, irq_sp=1.
